fuzzy_rule_engine: RTL and testbench
====================================

// Module: fuzzy_rule_engine
// PURPOSE
//  Parametrised successor to the fixed 7x7 fuzzy rule lookup: programmable N_LVL x N_LVL rule table plus max-min inference.
//  Takes error/error-change set indices with membership weights, fires the 4 adjacent rules sequentially and returns the strongest consequent label.
//  Sits between fuzzification and defuzzification/actuator stages; valid/ready on both sides, runtime-writable rule table.
// PARAMETERS
//  N_LVL        7    fuzzy sets per input (NBB..PBB); rule count = N_LVL*N_LVL
//  LVL_W        3    set-index width, >= clog2(N_LVL)
//  MU_W         8    membership weight width; MU_MAX = 2**MU_W-1
//  OUT_W        7    consequent label width
//  DEFAULT_LBL  24   table reset value and zero-strength fallback (ZE,ZE)
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          synchronous reset, active-high
//  in_valid    in   1          input request valid
//  in_ready    out  1          high only in IDLE
//  e_idx       in   LVL_W      lower active set of E; weight e_mu, set e_idx+1 gets MU_MAX-e_mu
//  e_mu        in   MU_W       membership of e_idx
//  ec_idx      in   LVL_W      lower active set of EC
//  ec_mu       in   MU_W       membership of ec_idx
//  cfg_we      in   1          rule table write strobe
//  cfg_addr    in   2*LVL_W    rule address = e*N_LVL+ec
//  cfg_data    in   OUT_W      consequent label to store
//  cfg_ready   out  1          write accepted this cycle (== state IDLE)
//  out_valid   out  1          result valid, held until out_ready
//  out_ready   in   1          downstream accepts result
//  out_df      out  OUT_W      winning consequent label
//  out_str     out  MU_W       firing strength of winning rule
//  out_num     out  MU_W+OUT_W+2  [FUZZY_CENTROID_EN only] sum(w_k*label_k)
//  out_den     out  MU_W+2     [FUZZY_CENTROID_EN only] sum(w_k)
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_df/out_str/out_num/out_den=0, all table entries=DEFAULT_LBL.
//  FSM IDLE -> EVAL(k=0..3) -> DONE -> IDLE. Accept on in_valid&in_ready at cycle T; inputs registered.
//  Rule order k: (e,ec),(e,ec+1),(e+1,ec),(e+1,ec+1); w_k = min(E weight, EC weight). One rule per cycle, T+1..T+4.
//  Winner: strictly greater w replaces best; ties keep earlier k. out_valid rises at T+5, outputs stable while out_valid&!out_ready.
//  DONE -> IDLE on out_valid&out_ready; in_ready high next cycle. Min spacing 6 cycles/request.
//  Boundary: idx >= N_LVL-1 -> idx and idx+1 both clamp to N_LVL-1 (duplicate rule still evaluated, counted in sums).
//  idx > N_LVL-1 on input clamped to N_LVL-1 at capture.
//  All w_k = 0 -> out_df=DEFAULT_LBL, out_str=0.
//  Table read combinational from register array; write in IDLE only, visible next cycle.
//  Write in the same cycle as accept: takes effect for that evaluation (first read at T+1).
//  cfg_we outside IDLE dropped (cfg_ready=0); cfg_addr >= N_LVL*N_LVL ignored.
//  rst mid-EVAL/DONE: transaction discarded, out_valid=0 next cycle, table reinitialised.
// CONFIGURATION
//  FUZZY_CENTROID_EN defined: accumulate out_num/out_den over the 4 rules (cleared at accept) for external divide.
//  Undefined: ports out_num/out_den absent, no multiplier/accumulators; max-min result only.
// STRUCTURE
//  fuzzy_pkg: state enum (IDLE,EVAL,DONE), MU_MAX, N_RULE=N_LVL*N_LVL, address-calc function.
//  Sub-module fuzzy_rule_ram: N_RULE x OUT_W register array, sync write, sync reset to DEFAULT_LBL, async read.
//  Top: FSM, k counter (2 bits), min/compare, optional accumulators.
// TESTING
//  Reset, table untouched; e=3,e_mu=255,ec=3,ec_mu=255 -> out_df=24,out_str=255 at T+5.
//  Write addr 17 =5 (e=2,ec=3); e=2,e_mu=200,ec=2,ec_mu=55 -> rule(2,3) w=200 wins, out_df=5,out_str=200.
//  Tie: e_mu=128,ec_mu=128, distinct labels all four -> k=0 label wins, out_str=128 (127 for others).
//  e=6,ec=6, mu=0 -> clamp, all rules addr 48, out_str=255, out_df=table[48].
//  out_ready low 10 cycles -> outputs stable, in_ready=0, cfg_we ignored; then handshake -> IDLE.
//  rst at T+2 -> out_valid never rises, in_ready=1 at T+3; FUZZY_CENTROID_EN: mu=255 both, table=24 -> num=24*255*... den=255+... per defined sums.

Source files
------------

// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared types, default sizes and rule address helper for the fuzzy rule engine
package fuzzy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_LVL = 7;
  localparam int DEF_LVL_W = 3;
  localparam int DEF_MU_W  = 8;
  localparam int DEF_OUT_W = 7;
  localparam int DEF_LBL   = 24;
  localparam int MU_MAX    = (1 << DEF_MU_W) - 1;
  localparam int N_RULE    = DEF_N_LVL * DEF_N_LVL;

  function automatic int rule_addr(input int e, input int ec, input int n_lvl);
    return e * n_lvl + ec;
  endfunction

endpackage

// File: rtl/fuzzy_rule_engine_if.sv
// rtl/fuzzy_rule_engine_if.sv - request/result/config bundle; out_num/out_den exist only with FUZZY_CENTROID_EN
interface fuzzy_rule_engine_if #(
  parameter int LVL_W = 3,
  parameter int MU_W  = 8,
  parameter int OUT_W = 7
);
  logic               in_valid;
  logic               in_ready;
  logic [LVL_W-1:0]   e_idx;
  logic [MU_W-1:0]    e_mu;
  logic [LVL_W-1:0]   ec_idx;
  logic [MU_W-1:0]    ec_mu;
  logic               cfg_we;
  logic [2*LVL_W-1:0] cfg_addr;
  logic [OUT_W-1:0]   cfg_data;
  logic               cfg_ready;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_df;
  logic [MU_W-1:0]    out_str;
`ifdef FUZZY_CENTROID_EN
  logic [MU_W+OUT_W+1:0] out_num;
  logic [MU_W+1:0]       out_den;

  modport master (
    output in_valid, e_idx, e_mu, ec_idx, ec_mu, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, cfg_ready, out_valid, out_df, out_str, out_num, out_den
  );
  modport slave (
    input  in_valid, e_idx, e_mu, ec_idx, ec_mu, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_ready, out_valid, out_df, out_str, out_num, out_den
  );
`else
  modport master (
    output in_valid, e_idx, e_mu, ec_idx, ec_mu, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, cfg_ready, out_valid, out_df, out_str
  );
  modport slave (
    input  in_valid, e_idx, e_mu, ec_idx, ec_mu, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_ready, out_valid, out_df, out_str
  );
`endif
endinterface

// File: rtl/fuzzy_rule_ram.sv
// rtl/fuzzy_rule_ram.sv - rule consequent table: sync write, sync reset to default label, async read
module fuzzy_rule_ram #(
  parameter int DEPTH       = 49,
  parameter int ADDR_W      = 6,
  parameter int OUT_W       = 7,
  parameter int DEFAULT_LBL = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [OUT_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [OUT_W-1:0]  rdata
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [OUT_W-1:0]  DEF_L   = OUT_W'(DEFAULT_LBL);

  logic [OUT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DEF_L;
    end else if (we && (waddr < DEPTH_A)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr < DEPTH_A) ? mem[raddr] : DEF_L;

endmodule

// File: rtl/fuzzy_rule_engine.sv
// rtl/fuzzy_rule_engine.sv - max-min inference over the 4 adjacent rules, one per cycle
// FUZZY_CENTROID_EN adds weighted-label/weight accumulators for an external divider.
module fuzzy_rule_engine
  import fuzzy_pkg::*;
#(
  parameter int N_LVL       = DEF_N_LVL,
  parameter int LVL_W       = DEF_LVL_W,
  parameter int MU_W        = DEF_MU_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int DEFAULT_LBL = DEF_LBL
) (
  input logic                clk,
  input logic                rst,
  fuzzy_rule_engine_if.slave bus
);
  localparam int ADDR_W = 2 * LVL_W;
  localparam int RULES  = N_LVL * N_LVL;
  localparam logic [LVL_W-1:0]  TOP_IDX  = LVL_W'(N_LVL - 1);
  localparam logic [ADDR_W-1:0] RULES_A  = ADDR_W'(RULES);
  localparam logic [OUT_W-1:0]  DEF_L    = OUT_W'(DEFAULT_LBL);
  localparam logic [MU_W-1:0]   MU_FULL  = '1;

  state_t           state;
  logic [1:0]       k;
  logic [LVL_W-1:0] e_lo, e_hi, ec_lo, ec_hi;
  logic [MU_W-1:0]  e_w_lo, e_w_hi, ec_w_lo, ec_w_hi;
  logic [MU_W-1:0]  best_w;
  logic [OUT_W-1:0] best_lbl;
  logic             valid_q;
  logic [OUT_W-1:0] df_q;
  logic [MU_W-1:0]  str_q;

  logic             idle;
  logic             ram_we;
  logic [LVL_W-1:0] e_sel, ec_sel, e_cap_lo, e_cap_hi, ec_cap_lo, ec_cap_hi;
  logic [MU_W-1:0]  w_e, w_ec, w_k;
  logic [ADDR_W-1:0] raddr;
  logic [OUT_W-1:0] lbl_k;
  logic             win;

  assign idle          = (state == IDLE);
  assign bus.in_ready  = idle;
  assign bus.cfg_ready = idle;
  assign bus.out_valid = valid_q;
  assign bus.out_df    = df_q;
  assign bus.out_str   = str_q;
  assign ram_we        = idle && bus.cfg_we && (bus.cfg_addr < RULES_A);

  // Top set has no upper neighbour, so both corners collapse onto it.
  always_comb begin
    e_cap_lo  = (bus.e_idx  >= TOP_IDX) ? TOP_IDX : bus.e_idx;
    e_cap_hi  = (bus.e_idx  >= TOP_IDX) ? TOP_IDX : bus.e_idx + 1'b1;
    ec_cap_lo = (bus.ec_idx >= TOP_IDX) ? TOP_IDX : bus.ec_idx;
    ec_cap_hi = (bus.ec_idx >= TOP_IDX) ? TOP_IDX : bus.ec_idx + 1'b1;
  end

  always_comb begin
    e_sel  = k[1] ? e_hi    : e_lo;
    ec_sel = k[0] ? ec_hi   : ec_lo;
    w_e    = k[1] ? e_w_hi  : e_w_lo;
    w_ec   = k[0] ? ec_w_hi : ec_w_lo;
    w_k    = (w_e < w_ec) ? w_e : w_ec;
    raddr  = ADDR_W'(rule_addr(int'(e_sel), int'(ec_sel), N_LVL));
    win    = (w_k > best_w);
  end

  fuzzy_rule_ram #(
    .DEPTH      (RULES),
    .ADDR_W     (ADDR_W),
    .OUT_W      (OUT_W),
    .DEFAULT_LBL(DEFAULT_LBL)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(bus.cfg_addr),
    .wdata(bus.cfg_data),
    .raddr(raddr),
    .rdata(lbl_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= 2'd0;
      e_lo     <= '0;
      e_hi     <= '0;
      ec_lo    <= '0;
      ec_hi    <= '0;
      e_w_lo   <= '0;
      e_w_hi   <= '0;
      ec_w_lo  <= '0;
      ec_w_hi  <= '0;
      best_w   <= '0;
      best_lbl <= DEF_L;
      valid_q  <= 1'b0;
      df_q     <= '0;
      str_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            e_lo     <= e_cap_lo;
            e_hi     <= e_cap_hi;
            ec_lo    <= ec_cap_lo;
            ec_hi    <= ec_cap_hi;
            e_w_lo   <= bus.e_mu;
            e_w_hi   <= MU_FULL - bus.e_mu;
            ec_w_lo  <= bus.ec_mu;
            ec_w_hi  <= MU_FULL - bus.ec_mu;
            k        <= 2'd0;
            best_w   <= '0;
            best_lbl <= DEF_L;
            state    <= EVAL;
          end
        end
        EVAL: begin
          if (win) begin
            best_w   <= w_k;
            best_lbl <= lbl_k;
          end
          k <= k + 2'd1;
          if (k == 2'd3) begin
            df_q    <= win ? lbl_k : best_lbl;
            str_q   <= win ? w_k : best_w;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FUZZY_CENTROID_EN
  localparam int NUM_W = MU_W + OUT_W + 2;
  localparam int DEN_W = MU_W + 2;

  logic [NUM_W-1:0] acc_num;
  logic [DEN_W-1:0] acc_den;

  always_ff @(posedge clk) begin
    if (rst || (idle && bus.in_valid)) begin
      acc_num <= '0;
      acc_den <= '0;
    end else if (state == EVAL) begin
      acc_num <= acc_num + NUM_W'(w_k) * NUM_W'(lbl_k);
      acc_den <= acc_den + DEN_W'(w_k);
    end
  end

  assign bus.out_num = acc_num;
  assign bus.out_den = acc_den;
`endif

endmodule

// File: tb/tb_fuzzy_rule_engine.sv
// tb/tb_fuzzy_rule_engine.sv - directed self-checking bench for fuzzy_rule_engine (FUZZY_CENTROID_EN aware)
module tb_fuzzy_rule_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fuzzy_rule_engine_if #(.LVL_W(3), .MU_W(8), .OUT_W(7)) bus ();

  fuzzy_rule_engine dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge where out_valid is seen.
  task automatic issue(input int e, input int emu, input int ec, input int ecmu);
    int lat;
    bus.e_idx    = 3'(e);
    bus.e_mu     = 8'(emu);
    bus.ec_idx   = 3'(ec);
    bus.ec_mu    = 8'(ecmu);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    check("busy_in_ready", 32'(bus.in_ready), 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 4);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hs_out_valid", 32'(bus.out_valid), 0);
    check("hs_in_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 6'(addr);
    bus.cfg_data = 7'(data);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.e_idx     = '0;
    bus.e_mu      = '0;
    bus.ec_idx    = '0;
    bus.ec_mu     = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_df", 32'(bus.out_df), 0);
    check("rst_out_str", 32'(bus.out_str), 0);
`ifdef FUZZY_CENTROID_EN
    check("rst_out_num", 32'(bus.out_num), 0);
    check("rst_out_den", 32'(bus.out_den), 0);
`endif

    // untouched table, single full-strength rule
    issue(3, 255, 3, 255);
    check("t1_df", 32'(bus.out_df), 24);
    check("t1_str", 32'(bus.out_str), 255);
`ifdef FUZZY_CENTROID_EN
    check("t1_num", 32'(bus.out_num), 24 * 255);
    check("t1_den", 32'(bus.out_den), 255);
`endif
    handshake();

    // rule (2,3) at address 17 wins with w=200
    cfg_write(17, 5);
    issue(2, 200, 2, 55);
    check("t2_df", 32'(bus.out_df), 5);
    check("t2_str", 32'(bus.out_str), 200);
`ifdef FUZZY_CENTROID_EN
    check("t2_num", 32'(bus.out_num), 55 * 24 * 3 + 200 * 5);
    check("t2_den", 32'(bus.out_den), 365);
`endif
    handshake();

    // distinct labels around (4,4)
    cfg_write(32, 10);
    cfg_write(33, 11);
    cfg_write(39, 12);
    cfg_write(40, 13);
    issue(4, 128, 4, 128);
    check("tie_df", 32'(bus.out_df), 10);
    check("tie_str", 32'(bus.out_str), 128);
    handshake();
    issue(4, 127, 4, 128);
    check("k2_df", 32'(bus.out_df), 12);
    check("k2_str", 32'(bus.out_str), 128);
    handshake();
    issue(4, 0, 4, 0);
    check("k3_df", 32'(bus.out_df), 13);
    check("k3_str", 32'(bus.out_str), 255);
    handshake();

    // top-set clamp, including out-of-range index
    cfg_write(48, 99);
    issue(6, 0, 6, 0);
    check("clamp_df", 32'(bus.out_df), 99);
    check("clamp_str", 32'(bus.out_str), 255);
    handshake();
    issue(7, 200, 7, 100);
    check("over_df", 32'(bus.out_df), 99);
    check("over_str", 32'(bus.out_str), 155);
    handshake();

    // out-of-range config address is ignored
    cfg_write(63, 1);
    issue(6, 0, 6, 0);
    check("badaddr_df", 32'(bus.out_df), 99);
    handshake();

    // write in the accept cycle is used by that evaluation
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 6'd0;
    bus.cfg_data = 7'd77;
    issue(0, 255, 0, 255);
    check("samecyc_df", 32'(bus.out_df), 77);
    check("samecyc_str", 32'(bus.out_str), 255);
    handshake();

    // backpressure: outputs hold, config writes dropped
    issue(6, 0, 6, 0);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 6'd48;
    bus.cfg_data = 7'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_out_df", 32'(bus.out_df), 99);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_cfg_ready", 32'(bus.cfg_ready), 0);
    end
    bus.cfg_we = 1'b0;
    handshake();
    issue(6, 0, 6, 0);
    check("bp_drop_df", 32'(bus.out_df), 99);
    handshake();

    // reset in the middle of evaluation
    bus.e_idx    = 3'd1;
    bus.e_mu     = 8'd255;
    bus.ec_idx   = 3'd1;
    bus.ec_mu    = 8'd255;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_in_ready", 32'(bus.in_ready), 1);
    check("mrst_out_valid", 32'(bus.out_valid), 0);
    check("mrst_out_df", 32'(bus.out_df), 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("mrst_no_valid", 32'(bus.out_valid), 0);
    end
    issue(6, 0, 6, 0);
    check("mrst_tbl48", 32'(bus.out_df), 24);
    handshake();
    issue(2, 200, 2, 55);
    check("mrst_tbl17_df", 32'(bus.out_df), 24);
    check("mrst_tbl17_str", 32'(bus.out_str), 200);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
